// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: sequencer states, default boot address and PC alignment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT             = 2'd0,
    RUN              = 2'd1,
    REDIRECT_PENDING = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/programCounterInputMux.sv
// Next-PC source select: in1 = sequential address, in2 = redirect target.
// Purely combinational, no backpressure.
module programCounterInputMux #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             select,
  output logic [WIDTH-1:0] muxOut
);

  assign muxOut = select ? in2 : in1;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: boot, sequential fetch and branch redirect; new PC visible one cycle after acceptance.
// Holds PC while imemReady=0 or stall=1; a redirect seen while memory is busy is parked until the fetch completes.
module pc_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned PC_STEP      = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        imemReady,
  output logic        imemReq,
  output logic [31:0] pcOut,
  output logic        pcIncrementOrJump,
  output logic        flushIfId
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pending_target_q, pending_target_d;
  logic [31:0]  aligned_target;
  logic [31:0]  redirect_target;
  logic [31:0]  next_pc;
  logic         pc_load;

  assign aligned_target  = align_pc(branchTarget);
  // A branch arriving in the completion cycle is newer than the parked target.
  assign redirect_target = branchTaken ? aligned_target : pending_target_q;

  programCounterInputMux #(.WIDTH(32)) u_next_pc_mux (
    .in1    (pc_q + STEP),
    .in2    (redirect_target),
    .select (pcIncrementOrJump),
    .muxOut (next_pc)
  );

  always_comb begin
    state_d           = state_q;
    pending_target_d  = pending_target_q;
    imemReq           = 1'b0;
    flushIfId         = 1'b0;
    pcIncrementOrJump = 1'b0;
    pc_load           = 1'b0;

    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        imemReq = 1'b1;
        if (branchTaken) begin
          flushIfId = 1'b1;
          if (imemReady) begin
            pcIncrementOrJump = 1'b1;
            pc_load           = 1'b1;
          end else begin
            pending_target_d = aligned_target;
            state_d          = REDIRECT_PENDING;
          end
        end else if (imemReady && !stall) begin
          pc_load = 1'b1;
        end
      end
      REDIRECT_PENDING: begin
        imemReq = 1'b1;
        if (branchTaken) begin
          flushIfId        = 1'b1;
          pending_target_d = aligned_target;
        end
        if (imemReady) begin
          flushIfId         = 1'b1;
          pcIncrementOrJump = 1'b1;
          pc_load           = 1'b1;
          state_d           = RUN;
        end
      end
      default: state_d = BOOT;
    endcase

    // Outputs are quiet for the whole reset cycle, whatever state we were in.
    if (!resetN) begin
      imemReq           = 1'b0;
      flushIfId         = 1'b0;
      pcIncrementOrJump = 1'b0;
      pc_load           = 1'b0;
    end

    pc_d = pc_load ? next_pc : pc_q;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q          <= BOOT;
      pc_q             <= RESET_VECTOR;
      pending_target_q <= 32'h0000_0000;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      pending_target_q <= pending_target_d;
    end
  end

  assign pcOut = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        imemReady;
  logic        imemReq;
  logic [31:0] pcOut;
  logic        pcIncrementOrJump;
  logic        flushIfId;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: fetch address, "still booting" flag and an optional parked redirect.
  logic [31:0] m_pc;
  logic        m_boot;
  logic        m_pend_vld;
  logic [31:0] m_pend;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk               (clk),
    .resetN            (resetN),
    .stall             (stall),
    .branchTaken       (branchTaken),
    .branchTarget      (branchTarget),
    .imemReady         (imemReady),
    .imemReq           (imemReq),
    .pcOut             (pcOut),
    .pcIncrementOrJump (pcIncrementOrJump),
    .flushIfId         (flushIfId)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs after the edge, check outputs mid-cycle, then advance the model.
  task automatic cyc(input logic rst_n, input logic br, input logic [31:0] tgt,
                     input logic st, input logic rd);
    logic [31:0] t;
    logic        redirect_now;
    @(posedge clk);
    #1;
    resetN       = rst_n;
    branchTaken  = br;
    branchTarget = tgt;
    stall        = st;
    imemReady    = rd;
    #3;
    t = {tgt[31:2], 2'b00};
    if (!rst_n) begin
      chk("rst_req", {31'd0, imemReq}, 32'd0);
      chk("rst_flush", {31'd0, flushIfId}, 32'd0);
      chk("rst_sel", {31'd0, pcIncrementOrJump}, 32'd0);
      m_pc = 32'h0; m_boot = 1'b1; m_pend_vld = 1'b0; m_pend = 32'h0;
    end else if (m_boot) begin
      chk("boot_req", {31'd0, imemReq}, 32'd0);
      chk("boot_pc", pcOut, 32'h0);
      chk("boot_flush", {31'd0, flushIfId}, 32'd0);
      chk("boot_sel", {31'd0, pcIncrementOrJump}, 32'd0);
      m_boot = 1'b0;
    end else begin
      redirect_now = rd && (br || m_pend_vld);
      chk("pc", pcOut, m_pc);
      chk("req", {31'd0, imemReq}, 32'd1);
      chk("flush", {31'd0, flushIfId}, {31'd0, br || (m_pend_vld && rd)});
      chk("sel", {31'd0, pcIncrementOrJump}, {31'd0, redirect_now});
      if (br && rd) begin
        m_pc = t; m_pend_vld = 1'b0;
      end else if (br) begin
        m_pend = t; m_pend_vld = 1'b1;
      end else if (m_pend_vld && rd) begin
        m_pc = m_pend; m_pend_vld = 1'b0;
      end else if (rd && !st) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    resetN = 1'b0; stall = 1'b0; branchTaken = 1'b0; branchTarget = '0; imemReady = 1'b0;
    m_pc = 32'h0; m_boot = 1'b1; m_pend_vld = 1'b0; m_pend = 32'h0;

    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    // Boot cycle, with a branch that must be ignored.
    cyc(1, 1, 32'h400, 0, 1);
    chk("boot_req0", {31'd0, imemReq}, 32'd0);
    cyc(1, 0, 0, 0, 1); chk("seq_0", pcOut, 32'h0);
    cyc(1, 0, 0, 0, 1); chk("seq_4", pcOut, 32'h4);
    cyc(1, 0, 0, 0, 1); chk("seq_8", pcOut, 32'h8);
    cyc(1, 0, 0, 0, 1); chk("seq_c", pcOut, 32'hC);

    // Memory not ready for three cycles at 0x10.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0);
      chk("hold_pc", pcOut, 32'h10);
      chk("hold_req", {31'd0, imemReq}, 32'd1);
    end
    cyc(1, 0, 0, 0, 1); chk("hold_done", pcOut, 32'h10);
    cyc(1, 0, 0, 0, 1); chk("after_hold", pcOut, 32'h14);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    // Branch with stall at 0x20: redirect wins, low target bits dropped.
    cyc(1, 1, 32'h103, 1, 1);
    chk("br_pc", pcOut, 32'h20);
    chk("br_flush", {31'd0, flushIfId}, 32'd1);
    chk("br_sel", {31'd0, pcIncrementOrJump}, 32'd1);
    // Two redirects while memory busy: newest wins.
    cyc(1, 1, 32'h200, 0, 0);
    chk("br_tgt", pcOut, 32'h100);
    chk("cap_flush", {31'd0, flushIfId}, 32'd1);
    cyc(1, 1, 32'h300, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("pend_hold", pcOut, 32'h100);
    chk("pend_noflush", {31'd0, flushIfId}, 32'd0);
    cyc(1, 0, 0, 0, 1);
    chk("pend_done_flush", {31'd0, flushIfId}, 32'd1);
    cyc(1, 0, 0, 0, 1);
    chk("pend_newest", pcOut, 32'h300);
    // Wrap at the top of the address space.
    cyc(1, 1, 32'hFFFF_FFFF, 0, 1);
    cyc(1, 0, 0, 0, 1); chk("wrap_top", pcOut, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 1); chk("wrap_zero", pcOut, 32'h0);
    // Reset while a redirect is parked.
    cyc(1, 1, 32'h400, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1); chk("rst_boot_pc", pcOut, 32'h0);
    cyc(1, 0, 0, 0, 1); chk("rst_first", pcOut, 32'h0);
    cyc(1, 0, 0, 0, 1); chk("rst_second", pcOut, 32'h4);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic r, b, s, d;
      r = ($urandom_range(0, 49) != 0);
      b = ($urandom_range(0, 5) == 0);
      s = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 3) != 0);
      cyc(r, b, $urandom, s, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
